// File: rtl/proc_host_seq.sv
// proc_host_seq: host-side sequencer that loads data memory, runs the processor via req/done, and streams a result window back.
module proc_host_seq #(
    parameter int AW      = 8,
    parameter int LD_BASE = 0,
    parameter int LD_LEN  = 64,
    parameter int RD_BASE = 64,
    parameter int RD_LEN  = 32,
    parameter int CW      = 16,
    parameter int TMO     = 4000
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic          in_valid,
    input  logic [7:0]    in_data,
    output logic          in_ready,
    output logic          mem_wr_en,
    output logic [AW-1:0] mem_addr,
    output logic [7:0]    mem_wdata,
    input  logic [7:0]    mem_rdata,
    output logic          proc_req,
    input  logic          proc_done,
    output logic          out_valid,
    output logic [7:0]    out_data,
    input  logic          out_ready,
    output logic          busy,
    output logic          fin,
    output logic          timeout,
    output logic [CW-1:0] cycles
);
    typedef enum logic [2:0] {S_IDLE, S_LOAD, S_REQ, S_WAIT, S_RD_ISSUE, S_RD_HOLD, S_FIN} state_t;
    state_t        r_state, w_next;
    logic [AW-1:0] r_ptr;
    logic [31:0]   r_cnt;
    logic [CW-1:0] r_cycles;
    logic [7:0]    r_dat;
    logic          r_armed, r_req, r_hold, r_timeout;
    logic [CW-1:0] w_cyc_n;
    logic          w_done, w_tmo, w_ld_last, w_rd_last;

    assign w_cyc_n   = r_cycles + 1'b1;
    assign w_done    = r_armed && proc_done;
    assign w_tmo     = w_cyc_n == CW'(TMO);
    assign w_ld_last = r_cnt == 32'(LD_LEN - 1);
    assign w_rd_last = r_cnt == 32'(RD_LEN - 1);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            r_state   <= S_IDLE;
            r_ptr     <= '0;
            r_cnt     <= '0;
            r_cycles  <= '0;
            r_dat     <= '0;
            r_armed   <= 1'b0;
            r_req     <= 1'b0;
            r_hold    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state <= w_next;
            r_req   <= w_next == S_REQ;
            if (r_state == S_IDLE && start) begin
                r_ptr     <= AW'(LD_BASE);
                r_cnt     <= '0;
                r_cycles  <= '0;
                r_timeout <= 1'b0;
            end
            if (r_state == S_LOAD && in_valid) begin
                r_ptr <= r_ptr + 1'b1;
                r_cnt <= r_cnt + 1;
            end
            if (r_state == S_REQ)
                r_armed <= 1'b0;
            if (r_state == S_WAIT) begin
                r_cycles <= w_cyc_n;
                if (!proc_done)
                    r_armed <= 1'b1;
                if (w_done) begin
                    r_ptr <= AW'(RD_BASE);
                    r_cnt <= '0;
                end else if (w_tmo)
                    r_timeout <= 1'b1;
            end
            // First RD_HOLD cycle forwards mem_rdata directly and latches it for any stall.
            if (r_state == S_RD_HOLD) begin
                r_hold <= !out_ready;
                if (!r_hold)
                    r_dat <= mem_rdata;
                if (out_ready) begin
                    r_ptr <= r_ptr + 1'b1;
                    r_cnt <= r_cnt + 1;
                end
            end
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE:     w_next = start ? (LD_LEN > 0 ? S_LOAD : S_REQ) : S_IDLE;
            S_LOAD:     w_next = (in_valid && w_ld_last) ? S_REQ : S_LOAD;
            S_REQ:      w_next = S_WAIT;
            S_WAIT:     w_next = w_done ? (RD_LEN > 0 ? S_RD_ISSUE : S_FIN) : w_tmo ? S_FIN : S_WAIT;
            S_RD_ISSUE: w_next = S_RD_HOLD;
            S_RD_HOLD:  w_next = out_ready ? (w_rd_last ? S_FIN : S_RD_ISSUE) : S_RD_HOLD;
            S_FIN:      w_next = S_IDLE;
            default:    w_next = S_IDLE;
        endcase
    end

    always_comb begin
        in_ready  = r_state == S_LOAD;
        mem_wr_en = in_ready && in_valid;
        mem_addr  = (r_state == S_LOAD || r_state == S_RD_ISSUE) ? r_ptr : '0;
        mem_wdata = in_ready ? in_data : '0;
        proc_req  = r_req;
        out_valid = r_state == S_RD_HOLD;
        out_data  = (out_valid && !r_hold) ? mem_rdata : r_dat;
        busy      = r_state != S_IDLE;
        fin       = r_state == S_FIN;
        timeout   = r_timeout;
        cycles    = r_cycles;
    end
endmodule

// File: tb/tb_proc_host_seq.sv
// tb_proc_host_seq: table-driven and randomized run sequences against a rule-level model of the host sequencer.
module tb_proc_host_seq;
    localparam int TMO = 100;
    logic        clk = 0, reset = 0, start = 0, in_valid = 0, proc_done = 0, out_ready = 0, tb_we = 0;
    logic [7:0]  in_data = 0, tb_a = 0, tb_d = 0;
    logic [7:0]  mem_rdata, mem_addr, mem_wdata, out_data;
    logic        in_ready, mem_wr_en, proc_req, out_valid, busy, fin, timeout;
    logic [15:0] cycles;
    logic [7:0]  mem [256];
    logic [7:0]  wl_a [$];
    logic [7:0]  wl_d [$];
    int          n_chk = 0, n_fail = 0;

    typedef struct {
        logic [31:0] d;
        logic [15:0] rd;
        bit          gap;
        int          dly;
        bit          stale;
        bit          tmo;
        int          stall;
        bit          mid;
        int          exp_cyc;
        bit          exp_to;
    } vec_t;
    vec_t tbl [5];

    proc_host_seq #(.AW(8), .LD_BASE(0), .LD_LEN(4), .RD_BASE(64), .RD_LEN(2), .CW(16), .TMO(TMO)) dut (
        .clk(clk), .reset(reset), .start(start), .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
        .mem_wr_en(mem_wr_en), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_rdata(mem_rdata),
        .proc_req(proc_req), .proc_done(proc_done), .out_valid(out_valid), .out_data(out_data),
        .out_ready(out_ready), .busy(busy), .fin(fin), .timeout(timeout), .cycles(cycles)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        if (tb_we) mem[tb_a] <= tb_d;
        else if (mem_wr_en) mem[mem_addr] <= mem_wdata;
        mem_rdata <= mem[mem_addr];
    end

    always @(posedge clk)
        if (mem_wr_en) begin
            wl_a.push_back(mem_addr);
            wl_d.push_back(mem_wdata);
        end

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", nm, act, exp);
        end
    endtask

    function automatic int model_cyc(input vec_t v);
        return v.tmo ? TMO : (v.stale ? v.dly + 1 : v.dly);
    endfunction

    task automatic preload(input logic [7:0] a, input logic [7:0] d);
        tb_a = a; tb_d = d; tb_we = 1;
        @(posedge clk); #1;
        tb_we = 0;
    endtask

    task automatic run_seq(input vec_t v);
        int ld_i, rd_i, req_t, last_hs, req_n, ov_n, stall, base, w, n;
        bit fin_seen;
        logic [7:0] rw [2];
        ld_i = 0; rd_i = 0; req_t = -1; last_hs = -1; req_n = 0; ov_n = 0; stall = v.stall; fin_seen = 0;
        rw[0] = v.rd[15:8]; rw[1] = v.rd[7:0];
        preload(8'd64, rw[0]);
        preload(8'd65, rw[1]);
        base = wl_a.size();
        proc_done = v.stale; in_valid = 0; out_ready = 0;
        start = 1; @(posedge clk); #1;
        for (int t = 1; t <= 600 && !fin_seen; t++) begin
            start = 0;
            if (t == 1) chk("clr_on_start", {busy, timeout, cycles}, {1'b1, 17'd0});
            if (proc_req) begin
                req_n++;
                if (req_t < 0) begin
                    req_t = t;
                    chk("req_after_load", t, last_hs + 1);
                end
            end
            w = req_t < 0 ? 0 : t - req_t;
            proc_done = req_t < 0 ? v.stale : v.tmo ? 1'b0 : v.stale ? (w != v.dly) : (w >= v.dly);
            if (in_ready && ld_i < 4) begin
                in_valid = !v.gap || (t % 2 == 0);
                in_data = v.d[31 - 8 * ld_i -: 8];
                if (in_valid) begin
                    ld_i++;
                    last_hs = t;
                end
            end else begin
                in_valid = 1; in_data = 8'hEE;
            end
            if (out_valid) begin
                ov_n++;
                if (rd_i < 2) chk("rd_data", out_data, rw[rd_i]);
                else chk("rd_count", rd_i, 1);
                out_ready = stall == 0;
                if (stall > 0) begin
                    stall--;
                    if (v.mid && stall == 2) start = 1;
                end else rd_i++;
            end else out_ready = 0;
            if (fin) begin
                fin_seen = 1;
                chk("cycles", cycles, v.exp_cyc);
                chk("timeout", timeout, v.exp_to);
                chk("rd_words", rd_i, v.exp_to ? 0 : 2);
                chk("ov_cycles", ov_n, v.exp_to ? 0 : 2 + v.stall);
                chk("req_pulses", req_n, 1);
            end
            @(posedge clk); #1;
        end
        start = 0; out_ready = 0;
        if (!fin_seen) chk("fin_budget", 0, 1);
        chk("idle_after_fin", {busy, fin}, 2'b00);
        @(posedge clk); #1;
        chk("stay_idle", busy, 0);
        in_valid = 0;
        n = wl_a.size() - base;
        chk("wr_count", n, 4);
        for (int i = 0; i < 4; i++)
            if (base + i < wl_a.size()) begin
                chk("wr_addr", wl_a[base + i], i);
                chk("wr_data", wl_d[base + i], v.d[31 - 8 * i -: 8]);
            end
    endtask

    task automatic reset_mid();
        int t;
        t = 0;
        proc_done = 0;
        start = 1; @(posedge clk); #1; start = 0;
        in_valid = 1; in_data = 8'h5C;
        while (!proc_req && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        chk("rst_req_seen", proc_req, 1);
        in_data = 8'hEE;
        repeat (3) @(posedge clk);
        #3;
        chk("pre_rst_cycles", cycles, 2);
        reset = 0; #1;
        chk("rst_async", {proc_req, in_ready, mem_wr_en, mem_addr, mem_wdata, out_valid, out_data, busy, fin, timeout, cycles}, 0);
        @(posedge clk); #1;
        reset = 1; in_valid = 0;
        @(posedge clk); #1;
        chk("no_resume", busy, 0);
    endtask

    initial begin
        vec_t v;
        reset = 0;
        repeat (3) @(posedge clk);
        #1;
        chk("rst_outputs", {proc_req, in_ready, mem_wr_en, mem_addr, mem_wdata, out_valid, out_data, busy, fin, timeout, cycles}, 0);
        reset = 1;
        @(posedge clk); #1;
        chk("idle_no_start", busy, 0);
        tbl[0] = '{d: 32'h11223344, rd: 16'hA55A, gap: 1, dly: 10,  stale: 0, tmo: 0, stall: 0, mid: 0, exp_cyc: 10,  exp_to: 0};
        tbl[1] = '{d: 32'h01020304, rd: 16'h1234, gap: 0, dly: 4,   stale: 1, tmo: 0, stall: 0, mid: 0, exp_cyc: 5,   exp_to: 0};
        tbl[2] = '{d: 32'hDEADBEEF, rd: 16'h7788, gap: 0, dly: 0,   stale: 0, tmo: 1, stall: 0, mid: 0, exp_cyc: 100, exp_to: 1};
        tbl[3] = '{d: 32'h0F1E2D3C, rd: 16'hC33C, gap: 1, dly: 2,   stale: 0, tmo: 0, stall: 5, mid: 1, exp_cyc: 2,   exp_to: 0};
        tbl[4] = '{d: 32'h55AA55AA, rd: 16'h9966, gap: 0, dly: 100, stale: 0, tmo: 0, stall: 0, mid: 0, exp_cyc: 100, exp_to: 0};
        for (int i = 0; i < 5; i++) run_seq(tbl[i]);
        for (int i = 0; i < 6; i++) begin
            v.d = $urandom;
            v.rd = 16'($urandom);
            v.gap = 1'($urandom);
            v.stale = 1'($urandom);
            v.dly = $urandom_range(2, 40);
            v.tmo = 0;
            v.stall = $urandom_range(0, 4);
            v.mid = 1'($urandom);
            v.exp_to = 0;
            v.exp_cyc = model_cyc(v);
            run_seq(v);
        end
        reset_mid();
        run_seq(tbl[0]);
        $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
        $finish;
    end
endmodule
